palette_index_encoder: RTL
==========================

PALETTE_INDEX_ENCODER -- requirements
Module: palette_index_encoder

Interface
REQ-001 SHALL have parameter: SEARCH_LEN, default 16, number of palette entries searched per pixel, legal range 1..16.
REQ-002 SHALL have port: Clk  input  1  rising-edge clock.
REQ-003 SHALL have port: Reset_n  input  1  reset, asynchronous, active-low; the block has one clock.
REQ-004 SHALL have port: pal_we  input  1  palette write enable.
REQ-005 SHALL have port: pal_addr  input  4  palette entry written.
REQ-006 SHALL have port: pal_data  input  12  entry colour, packed {R[11:8], G[7:4], B[3:0]}.
REQ-007 SHALL have port: in_valid  input  1  pixel offered.
REQ-008 SHALL have port: in_ready  output  1  pixel accepted when high with in_valid.
REQ-009 SHALL have port: in_rgb  input  12  pixel colour, same packing as pal_data.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  consumer takes result.
REQ-012 SHALL have port: out_index  output  4  nearest palette index.
REQ-013 SHALL have port: out_dist  output  6  Manhattan distance of chosen entry (max 45).
REQ-014 SHALL have port: out_exact  output  1  high when out_dist == 0.

Function
REQ-015 SHALL hold a 16x12-bit palette register file, written on a Clk edge when pal_we=1; the write is visible to comparisons from the next cycle.
REQ-016 SHALL implement FSM states IDLE, SEARCH and DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; on in_valid, SHALL latch in_rgb, clear the entry counter to 0, set best_dist=63 and best_idx=0, then go to SEARCH.
REQ-018 SEARCH: in_ready=0; each cycle SHALL compare entry[counter] using |dR|+|dG|+|dB| on unsigned 4-bit channels, giving a 6-bit result.
REQ-019 SHALL replace best only on strictly smaller distance, so ties resolve to the lowest index.
REQ-020 SHALL go to DONE after comparing entry SEARCH_LEN-1; otherwise the counter increments.
REQ-021 Latency: a pixel accepted at edge k SHALL produce out_valid=1 from edge k+SEARCH_LEN+1 (k+17 with the default).
REQ-022 DONE: out_valid=1 and in_ready=0; out_index, out_dist and out_exact SHALL be stable until out_valid && out_ready, then the FSM returns to IDLE.
REQ-023 SHALL not bypass DONE->IDLE->SEARCH; a new pixel SHALL be accepted no earlier than the cycle after the output handshake.
REQ-024 A palette write during SEARCH to an entry not yet compared SHALL affect the current result; a write to an already-compared entry SHALL not.
REQ-025 A write during DONE SHALL not alter the held outputs.
REQ-026 SEARCH_LEN=1 SHALL compare entry 0 only, with out_valid at k+2.

Reset
REQ-027 Reset_n=0 SHALL asynchronously force: state=IDLE, counter=0, all palette entries=12'h000, best_idx=0, best_dist=63, out_valid=0, out_index=0, out_dist=0, out_exact=0.
REQ-028 While Reset_n=0, in_ready SHALL be 0; it SHALL go to 1 on the first cycle after release.
REQ-029 Reset asserted mid-SEARCH or in DONE SHALL discard the pixel with no output produced.

Configuration
REQ-030 Macro PAL_EARLY_EXIT_EN is optional.
REQ-031 When PAL_EARLY_EXIT_EN is defined, a zero-distance compare in SEARCH SHALL end the search that cycle and enter DONE, with out_valid at k+counter+2.
REQ-032 When PAL_EARLY_EXIT_EN is undefined, SEARCH SHALL always run SEARCH_LEN cycles, and latency SHALL be fixed per REQ-021.

Verification
REQ-033 Reset, then check defaults: out_valid=0 and out_index=0; after release in_ready=1; pixel 12'h123 against an all-zero palette -> index 0, dist 6, exact 0.
REQ-034 Load entries 0..3 = 444, 99F, FC7, 152; pixel FC7 -> index 2, dist 0, exact 1; out_valid at k+17 without the macro, k+4 with PAL_EARLY_EXIT_EN.
REQ-035 Tie case: entries 1 and 5 both = 99F, all other entries = 000; pixel 99F -> index 1; pixel 98F -> index 1, dist 1.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; raising out_ready -> IDLE on the next edge.
REQ-037 During SEARCH at counter=3, write entry 10 = in_rgb -> index 10 result; write entry 0 = in_rgb instead -> result unchanged from the pre-write palette.
REQ-038 Pulse Reset_n low at SEARCH counter=7 -> no out_valid produced; after release the next pixel completes with normal latency.

Source files
------------

// File: rtl/palette_index_encoder.sv
// Nearest-colour palette lookup: each accepted 12-bit RGB pixel is compared against
// SEARCH_LEN palette entries (Manhattan distance). Optional macro: PAL_EARLY_EXIT_EN.
module palette_index_encoder #(
    parameter int SEARCH_LEN = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [11:0] pal_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_index,
    output logic [5:0]  out_dist,
    output logic        out_exact
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(SEARCH_LEN - 1);

    state_t      state_reg, state_next;
    logic [11:0] pal_reg [16];
    logic [11:0] pix_reg, pix_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  best_idx_reg, best_idx_next;
    logic [5:0]  best_dist_reg, best_dist_next;
    logic        out_valid_reg, out_valid_next;
    logic [3:0]  out_index_reg, out_index_next;
    logic [5:0]  out_dist_reg, out_dist_next;
    logic        out_exact_reg, out_exact_next;

    logic [11:0] cand_rgb;
    logic [5:0]  cur_dist;
    logic        last_cmp;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 16; i++) begin
                pal_reg[i] <= 12'h000;
            end
        end else if (pal_we) begin
            pal_reg[pal_addr] <= pal_data;
        end
    end

    assign cand_rgb = pal_reg[cnt_reg];

    // One absolute channel difference per colour component (B, G, R).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [3:0] pix_ch;
            logic [3:0] pal_ch;
            logic [3:0] diff;
            assign pix_ch = pix_reg[gi*4 +: 4];
            assign pal_ch = cand_rgb[gi*4 +: 4];
            assign diff   = (pix_ch >= pal_ch) ? (pix_ch - pal_ch) : (pal_ch - pix_ch);
        end
    endgenerate

    assign cur_dist = {2'b00, g_ch[0].diff} + {2'b00, g_ch[1].diff} + {2'b00, g_ch[2].diff};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            pix_reg       <= 12'h000;
            cnt_reg       <= 4'd0;
            best_idx_reg  <= 4'd0;
            best_dist_reg <= 6'd63;
            out_valid_reg <= 1'b0;
            out_index_reg <= 4'd0;
            out_dist_reg  <= 6'd0;
            out_exact_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pix_reg       <= pix_next;
            cnt_reg       <= cnt_next;
            best_idx_reg  <= best_idx_next;
            best_dist_reg <= best_dist_next;
            out_valid_reg <= out_valid_next;
            out_index_reg <= out_index_next;
            out_dist_reg  <= out_dist_next;
            out_exact_reg <= out_exact_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pix_next       = pix_reg;
        cnt_next       = cnt_reg;
        best_idx_next  = best_idx_reg;
        best_dist_next = best_dist_reg;
        out_valid_next = out_valid_reg;
        out_index_next = out_index_reg;
        out_dist_next  = out_dist_reg;
        out_exact_next = out_exact_reg;
        last_cmp       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    pix_next       = in_rgb;
                    cnt_next       = 4'd0;
                    best_idx_next  = 4'd0;
                    best_dist_next = 6'd63;
                    state_next     = SEARCH;
                end
            end
            SEARCH: begin
                // Strict compare keeps the lowest index on ties.
                if (cur_dist < best_dist_reg) begin
                    best_dist_next = cur_dist;
                    best_idx_next  = cnt_reg;
                end
                last_cmp = (cnt_reg == LAST_IDX);
`ifdef PAL_EARLY_EXIT_EN
                if (cur_dist == 6'd0) begin
                    last_cmp = 1'b1;
                end
`endif
                if (last_cmp) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                // First DONE cycle captures the result; afterwards it is held
                // until the consumer takes it.
                if (!out_valid_reg) begin
                    out_valid_next = 1'b1;
                    out_index_next = best_idx_reg;
                    out_dist_next  = best_dist_reg;
                    out_exact_next = (best_dist_reg == 6'd0);
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = Reset_n && (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out_index = out_index_reg;
    assign out_dist  = out_dist_reg;
    assign out_exact = out_exact_reg;

endmodule
